// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lights_pkg
// Brief   : Shared sizes, scanner state encoding and address helper for the
//           lights BRAM arbiter.
// Revision: 1.0
// ============================================================================
package lights_pkg;

    localparam int LIGHTS_WIDTH = 16;
    localparam int LIGHTS_DEPTH = 2048;
    localparam int LIGHTS_IDX_W = $clog2(LIGHTS_DEPTH);

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_RUN   = 2'd1,
        SCAN_DRAIN = 2'd2
    } scan_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lights_bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : lights_bram_arbiter_if
// Brief   : Host register-style request/response bus into the lights arbiter.
// Revision: 1.0
// ============================================================================
interface lights_bram_arbiter_if
    import lights_pkg::*;
#(
    parameter int WIDTH = LIGHTS_WIDTH
) ();

    logic             host_req_valid;
    logic             host_req_ready;
    logic             host_req_we;
    logic [31:0]      host_req_addr;
    logic [WIDTH-1:0] host_req_wdata;
    logic             host_rsp_valid;
    logic [WIDTH-1:0] host_rsp_rdata;
    logic             host_rsp_err;

    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );

    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/lights_scan_seq.sv
`default_nettype none
// ============================================================================
// Module  : lights_scan_seq
// Brief   : Full-memory scanner: state machine, index counter, output pipeline.
// Revision: 1.0
// ============================================================================
module lights_scan_seq
    import lights_pkg::*;
#(
    parameter int  WIDTH = LIGHTS_WIDTH,
    parameter int  DEPTH = LIGHTS_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             scan_start_i,
    input  wire logic             scan_ready_i,
    input  wire logic             grant_i,
    input  wire logic [WIDTH-1:0] bram_dout_i,
    output logic                  scan_req_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  scan_busy_o,
    output logic                  scan_data_valid_o,
    output logic [WIDTH-1:0]      scan_data_o,
    output logic [IDX_W-1:0]      scan_index_o,
    output logic                  scan_last_o,
    output logic                  scan_done_o
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             last_q;

    // Kept outside the FSM process: grant_i is derived from this request.
    assign scan_req_o = (state_q == SCAN_RUN) && scan_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            out_idx_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= grant_i;
            out_idx_q <= grant_i ? idx_q : '0;
            last_q    <= grant_i && (idx_q == C_LAST_IDX);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SCAN_IDLE: begin
                if (scan_start_i) begin
                    state_d = SCAN_RUN;
                    idx_d   = '0;
                end
            end
            SCAN_RUN: begin
                if (grant_i) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = SCAN_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SCAN_DRAIN: state_d = SCAN_IDLE;
            default:    state_d = SCAN_IDLE;
        endcase
    end

    assign idx_o             = idx_q;
    assign scan_busy_o       = (state_q != SCAN_IDLE);
    assign scan_data_valid_o = valid_q;
    assign scan_data_o       = valid_q ? bram_dout_i : '0;
    assign scan_index_o      = out_idx_q;
    assign scan_last_o       = last_q;
    assign scan_done_o       = last_q;

endmodule
`default_nettype wire

// File: rtl/lights_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lights_bram_arbiter
// Brief   : Shares the single-port lights BRAM between host and scanner.
// Revision: 1.0
// ============================================================================
module lights_bram_arbiter
    import lights_pkg::*;
#(
    parameter int  WIDTH      = LIGHTS_WIDTH,
    parameter int  DEPTH      = LIGHTS_DEPTH,
    parameter int  SCAN_BURST = 8,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(SCAN_BURST + 1)
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    lights_bram_arbiter_if.slave     host,
    input  wire logic                scan_start,
    input  wire logic                scan_ready,
    output logic                     scan_busy,
    output logic                     scan_data_valid,
    output logic [WIDTH-1:0]         scan_data,
    output logic [IDX_W-1:0]         scan_index,
    output logic                     scan_last,
    output logic                     scan_done,
    output logic                     bram_we,
    output logic [31:0]              bram_addr,
    output logic [WIDTH-1:0]         bram_din,
    input  wire logic [WIDTH-1:0]    bram_dout
);

    logic             w_scan_req;
    logic             w_grant_scan;
    logic             w_starve;
    logic             w_host_acc;
    logic             w_host_in_range;
    logic [IDX_W-1:0] w_scan_idx;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rsp_rd_q;

    lights_scan_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_scan_seq (
        .clk               (clk),
        .rst_n             (rst_n),
        .scan_start_i      (scan_start),
        .scan_ready_i      (scan_ready),
        .grant_i           (w_grant_scan),
        .bram_dout_i       (bram_dout),
        .scan_req_o        (w_scan_req),
        .idx_o             (w_scan_idx),
        .scan_busy_o       (scan_busy),
        .scan_data_valid_o (scan_data_valid),
        .scan_data_o       (scan_data),
        .scan_index_o      (scan_index),
        .scan_last_o       (scan_last),
        .scan_done_o       (scan_done)
    );

    // Scanner wins unless a waiting host has already seen SCAN_BURST scanner grants.
    assign w_starve        = (cnt_q == CNT_W'(SCAN_BURST));
    assign w_grant_scan    = w_scan_req && !w_starve;
    assign w_host_acc      = host.host_req_valid && !w_grant_scan;
    assign w_host_in_range = addr_in_range(host.host_req_addr, DEPTH);
    assign host.host_req_ready = !w_grant_scan;

    always_comb begin
        cnt_d = cnt_q;
        if (!host.host_req_valid || w_host_acc) begin
            cnt_d = '0;
        end else if (w_grant_scan) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (w_grant_scan) begin
            bram_addr = 32'(w_scan_idx);
        end else if (w_host_acc) begin
            bram_we   = host.host_req_we && w_host_in_range;
            bram_addr = host.host_req_addr;
            bram_din  = host.host_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rsp_valid_q <= w_host_acc;
            rsp_err_q   <= w_host_acc && !w_host_in_range;
            rsp_rd_q    <= w_host_acc && !host.host_req_we && w_host_in_range;
        end
    end

    assign host.host_rsp_valid = rsp_valid_q;
    assign host.host_rsp_err   = rsp_err_q;
    assign host.host_rsp_rdata = rsp_rd_q ? bram_dout : '0;

endmodule
`default_nettype wire
